fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the instruction memory and feeds decode.
- Owns the program counter and issues word-aligned read requests to imem (rd_en plus pc).
- Captures each returned word together with its PC in a small queue and presents it to decode over a valid/ready handshake.
- Handles branch/jump redirects, decode backpressure and misaligned redirect targets.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage, instruction memory and decode.
// The master side is the fetch unit and the slave side is its environment.
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_rd_en;
   logic [XLEN-1:0] imem_pc;
   logic [XLEN-1:0] imem_instr;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;
   logic            misaligned_err;

   modport master (
      output imem_rd_en, imem_pc, out_valid, out_instr, out_pc, misaligned_err,
      input  imem_instr, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_rd_en, imem_pc, out_valid, out_instr, out_pc, misaligned_err,
      output imem_instr, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency imem reads and
// queues {instr, pc} pairs for decode, with redirect flush and misaligned-target halt.
module fetch_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}},
   parameter int              FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int LW = AW + 2;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   logic [0:0]      state_r;
   logic [XLEN-1:0] fetch_pc_r;
   logic [XLEN-1:0] req_pc_r;
   logic            inflight_r;
   logic            err_r;
   logic [XLEN-1:0] q_instr_r [FIFO_DEPTH];
   logic [XLEN-1:0] q_pc_r    [FIFO_DEPTH];
   logic [AW-1:0]   rd_ptr_r;
   logic [AW-1:0]   wr_ptr_r;
   logic [CW-1:0]   count_r;

   logic            out_valid_s;
   logic            pop_s;
   logic            push_s;
   logic            issue_s;
   logic            misaligned_s;
   logic [LW-1:0]   level_s;
   logic [CW-1:0]   count_nx_s;

   // Handshake, credit and issue decisions for the current cycle
   always_comb begin
      out_valid_s  = 1'b0;
      issue_s      = 1'b0;
      if ((count_r != {CW{1'b0}}) && (state_r == ST_RUN)) begin
         out_valid_s = 1'b1;
      end else begin
         out_valid_s = 1'b0;
      end
      pop_s        = out_valid_s && bus.out_ready;
      // A response already in flight is never dropped, so it is counted as a used slot.
      push_s       = inflight_r && !bus.redirect_valid;
      level_s      = LW'(count_r) + LW'(inflight_r) - LW'(pop_s);
      if (!rst && (state_r == ST_RUN) && !bus.redirect_valid && (level_s < LW'(FIFO_DEPTH))) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
      count_nx_s   = count_r + CW'(push_s) - CW'(pop_s);
      misaligned_s = (bus.redirect_pc[1:0] != 2'b00);
   end

   assign bus.imem_rd_en     = issue_s;
   assign bus.imem_pc        = fetch_pc_r;
   assign bus.out_valid      = out_valid_s;
   assign bus.out_instr      = out_valid_s ? q_instr_r[rd_ptr_r] : {XLEN{1'b0}};
   assign bus.out_pc         = out_valid_s ? q_pc_r[rd_ptr_r] : {XLEN{1'b0}};
   assign bus.misaligned_err = err_r;

   // PC, in-flight tracking, queue pointers and run/halt state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_RUN;
         fetch_pc_r <= RESET_PC;
         req_pc_r   <= {XLEN{1'b0}};
         inflight_r <= 1'b0;
         err_r      <= 1'b0;
         rd_ptr_r   <= {AW{1'b0}};
         wr_ptr_r   <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
      end else if (bus.redirect_valid) begin
         // The low bits are dropped so imem_pc stays word aligned even while halted.
         fetch_pc_r <= {bus.redirect_pc[XLEN-1:2], 2'b00};
         inflight_r <= 1'b0;
         rd_ptr_r   <= {AW{1'b0}};
         wr_ptr_r   <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         case (misaligned_s)
            1'b1: begin
               state_r <= ST_HALT;
               err_r   <= 1'b1;
            end
            default: begin
               state_r <= ST_RUN;
            end
         endcase
      end else begin
         inflight_r <= issue_s;
         if (issue_s) begin
            fetch_pc_r <= fetch_pc_r + XLEN'(3'd4);
            req_pc_r   <= fetch_pc_r;
         end
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         count_r <= count_nx_s;
      end
   end

   // Queue storage written with each returned word and the PC it was fetched from
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            q_instr_r[i] <= {XLEN{1'b0}};
            q_pc_r[i]    <= {XLEN{1'b0}};
         end
      end else if (push_s) begin
         q_instr_r[wr_ptr_r] <= bus.imem_instr;
         q_pc_r[wr_ptr_r]    <= req_pc_r;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model compared every cycle,
// directed literal scenarios, a RESET_PC wrap instance and randomized traffic.
module tb_fetch_unit;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_unit_if #(.XLEN(32)) bus ();
   fetch_unit_if #(.XLEN(32)) wbus ();

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst), .bus(bus.master)
   );

   fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) u_wrap (
      .clk(clk), .rst(rst), .bus(wbus.master)
   );

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [31:0] m_q_pc[$];
   logic [31:0] m_q_in[$];
   bit          m_inflight;
   logic [31:0] m_infl_pc;
   logic [31:0] m_fetch_pc;
   bit          m_halt;
   bit          m_err;

   // sampled DUT outputs
   logic        s_valid, s_rd, s_err;
   logic [31:0] s_pc, s_instr, s_ipc;

   bit          prev_req, w_prev_req;
   logic [31:0] prev_pc, w_prev_pc;
   logic [31:0] w_pcs[$];
   logic [31:0] w_ins[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_q_pc.delete();
      m_q_in.delete();
      m_inflight = 1'b0;
      m_infl_pc  = 32'h0;
      m_fetch_pc = 32'h0000_0000;
      m_halt     = 1'b0;
      m_err      = 1'b0;
   endtask

   // One clock cycle: called just after a falling edge, returns at the next one.
   task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rdy);
      bit e_valid, pop, e_rd;
      int lvl;
      bus.imem_instr      = prev_req ? mem_word(prev_pc) : $urandom;
      bus.redirect_valid  = rv;
      bus.redirect_pc     = rpc;
      bus.out_ready       = rdy;
      wbus.imem_instr     = w_prev_req ? mem_word(w_prev_pc) : $urandom;
      wbus.redirect_valid = 1'b0;
      wbus.redirect_pc    = 32'h0;
      wbus.out_ready      = 1'b1;
      #1;
      s_valid = bus.out_valid;
      s_pc    = bus.out_pc;
      s_instr = bus.out_instr;
      s_rd    = bus.imem_rd_en;
      s_ipc   = bus.imem_pc;
      s_err   = bus.misaligned_err;

      e_valid = !m_halt && (m_q_pc.size() > 0);
      pop     = e_valid && rdy;
      lvl     = m_q_pc.size() + int'(m_inflight) - int'(pop);
      e_rd    = !m_halt && !rv && (lvl < DEPTH);

      chk("out_valid", {31'b0, s_valid}, {31'b0, e_valid});
      if (e_valid) begin
         chk("out_pc", s_pc, m_q_pc[0]);
         chk("out_instr", s_instr, m_q_in[0]);
      end
      chk("imem_rd_en", {31'b0, s_rd}, {31'b0, e_rd});
      if (e_rd) chk("imem_pc", s_ipc, m_fetch_pc);
      chk("misaligned_err", {31'b0, s_err}, {31'b0, m_err});

      if (rv) begin
         m_q_pc.delete();
         m_q_in.delete();
         m_inflight = 1'b0;
         m_fetch_pc = {rpc[31:2], 2'b00};
         if (rpc[1:0] != 2'b00) begin
            m_halt = 1'b1;
            m_err  = 1'b1;
         end else begin
            m_halt = 1'b0;
         end
      end else begin
         if (pop) begin
            void'(m_q_pc.pop_front());
            void'(m_q_in.pop_front());
         end
         if (m_inflight) begin
            m_q_pc.push_back(m_infl_pc);
            m_q_in.push_back(mem_word(m_infl_pc));
         end
         m_inflight = e_rd;
         if (e_rd) begin
            m_infl_pc  = m_fetch_pc;
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end

      prev_req = s_rd;
      prev_pc  = s_ipc;
      if (wbus.out_valid && (w_pcs.size() < 3)) begin
         w_pcs.push_back(wbus.out_pc);
         w_ins.push_back(wbus.out_instr);
      end
      w_prev_req = wbus.imem_rd_en;
      w_prev_pc  = wbus.imem_pc;
      @(negedge clk);
   endtask

   // Asynchronous reset in mid-cycle, outputs checked before any clock edge.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_rd_en", {31'b0, bus.imem_rd_en}, 32'd0);
      chk("rst_err", {31'b0, bus.misaligned_err}, 32'd0);
      chk("rst_out_instr", bus.out_instr, 32'd0);
      chk("rst_out_pc", bus.out_pc, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      prev_req   = 1'b0;
      w_prev_req = 1'b0;
   endtask

   initial begin
      bit          rv, rdy;
      logic [31:0] rpc;
      int          r;
      rst = 1'b0;
      bus.imem_instr = 32'h0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.out_ready = 1'b0;
      wbus.imem_instr = 32'h0; wbus.redirect_valid = 1'b0; wbus.redirect_pc = 32'h0; wbus.out_ready = 1'b1;
      prev_req = 1'b0; prev_pc = 32'h0; w_prev_req = 1'b0; w_prev_pc = 32'h0;
      m_reset();
      @(negedge clk);

      // streaming after reset
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 32'h0, 1'b1);
         if (i < 3) begin
            chk("t1_rd", {31'b0, s_rd}, 32'd1);
            chk("t1_ipc", s_ipc, 32'(4 * i));
         end
         if (i < 2) chk("t1_novalid", {31'b0, s_valid}, 32'd0);
         else begin
            chk("t1_valid", {31'b0, s_valid}, 32'd1);
            chk("t1_pc", s_pc, 32'(4 * (i - 2)));
            chk("t1_instr", s_instr, 32'h1000_0000 + 32'(i - 2));
         end
      end

      // backpressure
      do_reset();
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 32'h0, 1'b0);
         chk("t2_rd_stall", {31'b0, s_rd}, 32'd0);
         chk("t2_head_pc", s_pc, 32'h0);
         chk("t2_head_instr", s_instr, 32'h1000_0000);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 32'h0, 1'b1);
         chk("t2_valid", {31'b0, s_valid}, 32'd1);
         chk("t2_pc", s_pc, 32'(4 * i));
         chk("t2_instr", s_instr, 32'h1000_0000 + 32'(i));
      end

      // redirect with pc 8 in flight
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b1, 32'h40, 1'b1);
      chk("t3_rd_redir", {31'b0, s_rd}, 32'd0);
      cycle(1'b0, 32'h0, 1'b1);
      chk("t3_v1", {31'b0, s_valid}, 32'd0);
      chk("t3_ipc", s_ipc, 32'h40);
      cycle(1'b0, 32'h0, 1'b1);
      chk("t3_v2", {31'b0, s_valid}, 32'd0);
      cycle(1'b0, 32'h0, 1'b1);
      chk("t3_v3", {31'b0, s_valid}, 32'd1);
      chk("t3_pc", s_pc, 32'h40);
      chk("t3_instr", s_instr, 32'h1000_0010);

      // misaligned redirect, then recovery
      cycle(1'b1, 32'h42, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 32'h0, 1'b1);
         chk("t4_err", {31'b0, s_err}, 32'd1);
         chk("t4_valid", {31'b0, s_valid}, 32'd0);
         chk("t4_rd", {31'b0, s_rd}, 32'd0);
      end
      cycle(1'b1, 32'h80, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      chk("t4_ipc", s_ipc, 32'h80);
      chk("t4_rd_resume", {31'b0, s_rd}, 32'd1);
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      chk("t4_pc", s_pc, 32'h80);
      chk("t4_err_sticky", {31'b0, s_err}, 32'd1);

      // reset with a request in flight and the credit exhausted
      do_reset();
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0);
      do_reset();
      cycle(1'b0, 32'h0, 1'b1);
      chk("t5_ipc", s_ipc, 32'h0);
      cycle(1'b0, 32'h0, 1'b1);
      chk("t5_novalid", {31'b0, s_valid}, 32'd0);
      cycle(1'b0, 32'h0, 1'b1);
      chk("t5_pc", s_pc, 32'h0);
      chk("t5_instr", s_instr, 32'h1000_0000);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 999);
         if (r < 3) begin
            do_reset();
         end else begin
            rv  = (r < 60);
            if (r < 10)      rpc = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(1, 3));
            else if (r < 20) rpc = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
            else             rpc = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            rdy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
            cycle(rv, rpc, rdy);
         end
      end

      // RESET_PC wrap instance
      chk("wrap_count", w_pcs.size(), 32'd3);
      if (w_pcs.size() == 3) begin
         chk("wrap_pc0", w_pcs[0], 32'hFFFF_FFF8);
         chk("wrap_in0", w_ins[0], 32'h4FFF_FFFE);
         chk("wrap_pc1", w_pcs[1], 32'hFFFF_FFFC);
         chk("wrap_in1", w_ins[1], 32'h4FFF_FFFF);
         chk("wrap_pc2", w_pcs[2], 32'h0000_0000);
         chk("wrap_in2", w_ins[2], 32'h1000_0000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
